// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the bitcoin job controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bitcoin_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } job_state_t;

  localparam int HDR_WORDS = 20;
  localparam int RES_WORDS = 9;

  // Header word index of the first word of each field.
  localparam int W_VERSION = 0;
  localparam int W_PREV    = 1;
  localparam int W_MERKLE  = 9;
  localparam int W_TIME    = 17;
  localparam int W_NBITS   = 18;
  localparam int W_NONCE   = 19;

endpackage

// File: rtl/bitcoin_job_ctrl.sv
// Purpose: unpack a 20-word header into bitcoin_block fields, run one job, stream 9 result words back.
// Latency: start one cycle after w19 is accepted; first result word one cycle after the done edge.
// Backpressure: s_ready low outside LOAD; result words hold on m_data until m_ready accepts them.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready      header word stream in (20 words, s_last on w19)
//   start                              one-cycle pulse to bitcoin_block
//   blk_version .. blk_nonce           header field buses, stable while the job runs
//   bitcoin_blk/nonce/done             result and completion from bitcoin_block
//   m_data/m_valid/m_last/m_ready      result word stream out (hash r0..r7, nonce r8)
//   hdr_err, timeout                   one-cycle error pulses
module bitcoin_job_ctrl
  import bitcoin_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         start,
  output logic [31:0]  blk_version,
  output logic [255:0] prev_blk_header_hash,
  output logic [255:0] merkle_root_hash,
  output logic [31:0]  blk_time,
  output logic [31:0]  blk_nbits,
  output logic [31:0]  blk_nonce,
  input  logic [255:0] bitcoin_blk,
  input  logic [31:0]  bitcoin_nonce,
  input  logic         bitcoin_done,
  output logic [31:0]  m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         hdr_err,
  output logic         timeout
);

  localparam logic [4:0]  LAST_W   = 5'(HDR_WORDS - 1);
  localparam logic [3:0]  LAST_R   = 4'(RES_WORDS - 1);
  // Counter value on which the timeout fires; unused when TIMEOUT_CYCLES is 0.
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  job_state_t   state;
  logic [4:0]   wcnt;
  logic [3:0]   ridx;
  logic [31:0]  wait_cnt;
  logic         done_q;
  logic [255:0] res_hash;
  logic [31:0]  res_nonce;
  logic [31:0]  nxt_word;

  // Result word idx: 0..7 are hash words MSB first, anything else is the nonce.
  function automatic logic [31:0] res_word(input logic [255:0] h, input logic [31:0] n,
                                           input logic [3:0] idx);
    logic [31:0] w;
    w = n;
    for (int i = 0; i < 8; i++) begin
      if (idx == 4'(i)) w = h[255 - 32*i -: 32];
    end
    return w;
  endfunction

  // Word that m_data moves to after the current one is accepted.
  always_comb begin
    nxt_word = res_word(res_hash, res_nonce, ridx + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= LOAD;
      wcnt                 <= '0;
      ridx                 <= '0;
      wait_cnt             <= '0;
      done_q               <= 1'b0;
      res_hash             <= '0;
      res_nonce            <= '0;
      s_ready              <= 1'b0;
      start                <= 1'b0;
      m_valid              <= 1'b0;
      m_last               <= 1'b0;
      m_data               <= '0;
      hdr_err              <= 1'b0;
      timeout              <= 1'b0;
      blk_version          <= '0;
      prev_blk_header_hash <= '0;
      merkle_root_hash     <= '0;
      blk_time             <= '0;
      blk_nbits            <= '0;
      blk_nonce            <= '0;
    end else begin
      start   <= 1'b0;
      hdr_err <= 1'b0;
      timeout <= 1'b0;

      // Forcing the previous value high on the way into WAIT means a done
      // level left over from the last job must drop and rise again.
      if (state == START) done_q <= 1'b1;
      else                done_q <= bitcoin_done;

      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            if (wcnt == 5'(W_VERSION)) blk_version <= s_data;
            for (int i = 0; i < 8; i++) begin
              if (wcnt == 5'(W_PREV + i))   prev_blk_header_hash[255 - 32*i -: 32] <= s_data;
              if (wcnt == 5'(W_MERKLE + i)) merkle_root_hash[255 - 32*i -: 32]     <= s_data;
            end
            if (wcnt == 5'(W_TIME))  blk_time  <= s_data;
            if (wcnt == 5'(W_NBITS)) blk_nbits <= s_data;
            if (wcnt == 5'(W_NONCE)) blk_nonce <= s_data;

            // s_last must coincide exactly with the final word.
            if (s_last != (wcnt == LAST_W)) begin
              hdr_err <= 1'b1;
              wcnt    <= '0;
            end else if (s_last) begin
              wcnt    <= '0;
              start   <= 1'b1;
              s_ready <= 1'b0;
              state   <= START;
            end else begin
              wcnt <= wcnt + 5'd1;
            end
          end
        end

        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (bitcoin_done && !done_q) begin
            res_hash  <= bitcoin_blk;
            res_nonce <= bitcoin_nonce;
            ridx      <= '0;
            m_data    <= bitcoin_blk[255:224];
            m_last    <= 1'b0;
            m_valid   <= 1'b1;
            state     <= SEND;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TO_LAST) begin
            timeout <= 1'b1;
            s_ready <= 1'b1;
            state   <= LOAD;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        SEND: begin
          if (m_ready) begin
            if (ridx == LAST_R) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              s_ready <= 1'b1;
              state   <= LOAD;
            end else begin
              ridx   <= ridx + 4'd1;
              m_data <= nxt_word;
              m_last <= ((ridx + 4'd1) == LAST_R);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_job_ctrl.sv
// Bench for bitcoin_job_ctrl; the bench itself plays the bitcoin_block side.
// Latency: n/a.
// Backpressure: drives m_ready high, toggling or random.
module tb_bitcoin_job_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         start;
  logic [31:0]  blk_version;
  logic [255:0] prev_blk_header_hash;
  logic [255:0] merkle_root_hash;
  logic [31:0]  blk_time;
  logic [31:0]  blk_nbits;
  logic [31:0]  blk_nonce;
  logic [255:0] bitcoin_blk;
  logic [31:0]  bitcoin_nonce;
  logic         bitcoin_done;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic         hdr_err;
  logic         timeout;

  always #5 clk = ~clk;

  bitcoin_job_ctrl #(.TIMEOUT_CYCLES(50)) dut (
    .clk                  (clk),
    .reset                (reset),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_last               (s_last),
    .s_ready              (s_ready),
    .start                (start),
    .blk_version          (blk_version),
    .prev_blk_header_hash (prev_blk_header_hash),
    .merkle_root_hash     (merkle_root_hash),
    .blk_time             (blk_time),
    .blk_nbits            (blk_nbits),
    .blk_nonce            (blk_nonce),
    .bitcoin_blk          (bitcoin_blk),
    .bitcoin_nonce        (bitcoin_nonce),
    .bitcoin_done         (bitcoin_done),
    .m_data               (m_data),
    .m_valid              (m_valid),
    .m_last               (m_last),
    .m_ready              (m_ready),
    .hdr_err              (hdr_err),
    .timeout              (timeout)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] nom_hdr [20];
  logic [31:0] nom_res [9];
  logic [31:0] hdr [20];   // header of the current job
  logic [31:0] res [9];    // result words the stub returns and the stream must carry

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Eight consecutive header words glued together, first word most significant.
  function automatic logic [255:0] pack8(input int base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], hdr[base + i]};
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk1  ({tag, "_s_ready"}, s_ready, 1'b0);
    chk1  ({tag, "_start"},   start,   1'b0);
    chk1  ({tag, "_m_valid"}, m_valid, 1'b0);
    chk1  ({tag, "_m_last"},  m_last,  1'b0);
    chk1  ({tag, "_hdr_err"}, hdr_err, 1'b0);
    chk1  ({tag, "_timeout"}, timeout, 1'b0);
    chk32 ({tag, "_m_data"},  m_data,  32'h0);
    chk32 ({tag, "_version"}, blk_version, 32'h0);
    chk256({tag, "_prev"},    prev_blk_header_hash, 256'h0);
    chk256({tag, "_merkle"},  merkle_root_hash, 256'h0);
    chk32 ({tag, "_time"},    blk_time,  32'h0);
    chk32 ({tag, "_nbits"},   blk_nbits, 32'h0);
    chk32 ({tag, "_nonce"},   blk_nonce, 32'h0);
  endtask

  // Streams hdr[0..nwords-1]; s_last goes with word last_pos (-1: never).
  task automatic send_hdr(input int nwords, input int last_pos, input int max_gap);
    for (int i = 0; i < nwords; i++) begin
      int n;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat ($urandom_range(max_gap, 0)) tick;
      s_valid = 1'b1;
      s_data  = hdr[i];
      s_last  = (i == last_pos);
      n = 0;
      while (!s_ready && n < 200) begin
        tick;
        n++;
      end
      chk1($sformatf("hdr_ready_w%0d", i), s_ready, 1'b1);
      tick;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called right after the w19 handshake edge.
  task automatic expect_start(input string tag);
    chk1  ({tag, "_start"},      start,   1'b1);
    chk1  ({tag, "_s_ready_lo"}, s_ready, 1'b0);
    chk32 ({tag, "_version"},    blk_version, hdr[0]);
    chk256({tag, "_prev"},       prev_blk_header_hash, pack8(1));
    chk256({tag, "_merkle"},     merkle_root_hash, pack8(9));
    chk32 ({tag, "_time"},       blk_time,  hdr[17]);
    chk32 ({tag, "_nbits"},      blk_nbits, hdr[18]);
    chk32 ({tag, "_nonce"},      blk_nonce, hdr[19]);
    tick;
    chk1  ({tag, "_start_pulse"}, start, 1'b0);
  endtask

  // mode 0: m_ready always high, 1: toggles every cycle, 2: random.
  task automatic collect(input string tag, input int mode);
    int k;
    int n;
    k = 0;
    n = 0;
    while (k < 9 && n < 300) begin
      chk1 ($sformatf("%s_m_valid_%0d", tag, k), m_valid, 1'b1);
      chk32($sformatf("%s_m_data_%0d", tag, k),  m_data,  res[k]);
      chk1 ($sformatf("%s_m_last_%0d", tag, k),  m_last,  (k == 8));
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (n % 2 == 0);
        default: m_ready = 1'($urandom_range(1, 0));
      endcase
      tick;
      n++;
      if (m_ready) k++;
    end
    m_ready = 1'b0;
    chk32({tag, "_words"}, 32'(k), 32'd9);
    chk1 ({tag, "_m_valid_end"}, m_valid, 1'b0);
    chk1 ({tag, "_s_ready_end"}, s_ready, 1'b1);
    if (mode == 0) chk32({tag, "_throughput"}, 32'(n), 32'd9);
  endtask

  task automatic load_result;
    for (int i = 0; i < 8; i++) bitcoin_blk = {bitcoin_blk[223:0], res[i]};
    bitcoin_nonce = res[8];
  endtask

  // Called in WAIT; done is brought low, then raised after delay cycles.
  task automatic finish_job(input string tag, input int delay, input int mode, input bit keep);
    bitcoin_done = 1'b0;
    repeat (delay) begin
      tick;
      chk1({tag, "_no_valid_in_wait"}, m_valid, 1'b0);
    end
    load_result();
    bitcoin_done = 1'b1;
    tick;
    chk1({tag, "_first_valid"}, m_valid, 1'b1);
    collect(tag, mode);
    if (!keep) bitcoin_done = 1'b0;
  endtask

  task automatic random_job_data;
    for (int i = 0; i < 20; i++) hdr[i] = $urandom;
    for (int i = 0; i < 9; i++)  res[i] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    nom_hdr = '{32'h02000000,
                32'h671D0E2F, 32'h3E3AB5B1, 32'h8C9A2D0F, 32'h5E4A7C11,
                32'h1B8F0D42, 32'h2F000000, 32'h00000000, 32'h00000000,
                32'h2CD900FC, 32'h9A1B77E3, 32'h6D5C0B28, 32'hE4F1A390,
                32'h0C7E2B56, 32'hB83D19A4, 32'h7F60E21D, 32'h45F4992E,
                32'h74749054, 32'h747B1B18, 32'h43F740C0};
    nom_res = '{32'hFF277F1F, 32'h11CD72EF, 32'hFE537F5E, 32'h8A2690E0,
                32'h8D8C9116, 32'h82D8A815, 32'h00000000, 32'h00000000,
                32'h43F740C0};

    reset         = 1'b1;
    s_data        = '0;
    s_valid       = 1'b0;
    s_last        = 1'b0;
    m_ready       = 1'b0;
    bitcoin_blk   = '0;
    bitcoin_nonce = '0;
    bitcoin_done  = 1'b0;
    hdr           = nom_hdr;
    res           = nom_res;

    // Reset state.
    tick;
    tick;
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick;
    chk1("rst_release_s_ready", s_ready, 1'b1);

    // Nominal job.
    send_hdr(20, 19, 0);
    expect_start("nom");
    finish_job("nom", 3, 0, 1'b0);

    // Result backpressure.
    send_hdr(20, 19, 0);
    expect_start("bp");
    finish_job("bp", 5, 1, 1'b0);

    // Input gaps.
    send_hdr(20, 19, 3);
    expect_start("gap");
    finish_job("gap", 2, 2, 1'b0);

    // Framing error: early s_last on w5.
    send_hdr(6, 5, 0);
    chk1("frm_early_hdr_err", hdr_err, 1'b1);
    chk1("frm_early_no_start", start, 1'b0);
    chk1("frm_early_s_ready", s_ready, 1'b1);
    tick;
    chk1("frm_early_hdr_err_pulse", hdr_err, 1'b0);
    chk1("frm_early_no_start2", start, 1'b0);
    // Framing error: s_last missing on w19.
    send_hdr(20, -1, 0);
    chk1("frm_nolast_hdr_err", hdr_err, 1'b1);
    chk1("frm_nolast_no_start", start, 1'b0);
    tick;
    chk1("frm_nolast_hdr_err_pulse", hdr_err, 1'b0);
    send_hdr(20, 19, 0);
    expect_start("frm_ok");
    finish_job("frm_ok", 4, 0, 1'b1);

    // Done still high from the last job: must not trigger the next one.
    random_job_data();
    send_hdr(20, 19, 1);
    expect_start("stale");
    repeat (5) begin
      tick;
      chk1("stale_no_valid", m_valid, 1'b0);
    end
    finish_job("stale", 2, 2, 1'b0);

    // Timeout: done never rises.
    random_job_data();
    send_hdr(20, 19, 0);
    expect_start("to");
    begin
      int t;
      bit mv_seen;
      t = 0;
      mv_seen = 1'b0;
      while (timeout !== 1'b1 && t < 200) begin
        tick;
        t++;
        if (m_valid) mv_seen = 1'b1;
      end
      chk32("to_cycles_after_wait", 32'(t), 32'd50);
      chk1 ("to_no_valid", mv_seen, 1'b0);
      chk1 ("to_s_ready", s_ready, 1'b1);
      tick;
      chk1 ("to_pulse", timeout, 1'b0);
      chk1 ("to_no_valid_after", m_valid, 1'b0);
    end
    hdr = nom_hdr;
    res = nom_res;
    send_hdr(20, 19, 0);
    expect_start("to_next");
    finish_job("to_next", 2, 0, 1'b0);

    // Reset while in WAIT.
    send_hdr(20, 19, 0);
    expect_start("rw");
    repeat (3) tick;
    reset = 1'b1;
    tick;
    chk_reset_outputs("rst_wait");
    reset = 1'b0;
    tick;
    chk1("rst_wait_release_s_ready", s_ready, 1'b1);

    // Reset in SEND with four words already taken.
    random_job_data();
    send_hdr(20, 19, 0);
    expect_start("rs");
    tick;
    load_result();
    bitcoin_done = 1'b1;
    tick;
    chk1("rs_first_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    repeat (4) tick;
    m_ready = 1'b0;
    chk32("rs_ridx4_data", m_data, res[4]);
    reset = 1'b1;
    tick;
    chk_reset_outputs("rst_send");
    reset = 1'b0;
    bitcoin_done = 1'b0;
    tick;
    chk1("rst_send_release_s_ready", s_ready, 1'b1);

    // Random jobs.
    for (int j = 0; j < 3; j++) begin
      random_job_data();
      send_hdr(20, 19, 2);
      expect_start($sformatf("rnd%0d", j));
      finish_job($sformatf("rnd%0d", j), int'($urandom_range(20, 1)), 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
